// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit: FSM states,
// byte-enable patterns, load/store funct3 encodings and request legality.
package riscv_lsu_pkg;

    localparam int NB_BE = 4;

    localparam logic [NB_BE-1:0] BE_BYTE = 4'b0001;
    localparam logic [NB_BE-1:0] BE_HALF = 4'b0011;
    localparam logic [NB_BE-1:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        ST_SB = 3'b000,
        ST_SH = 3'b001,
        ST_SW = 3'b010
    } store_funct3_t;

    // A request is legal when it is exactly one of load/store, uses a defined
    // width encoding and is naturally aligned for that width.
    function automatic logic lsu_req_legal(input logic       rd,
                                           input logic       wr,
                                           input logic [2:0] funct3,
                                           input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else if (rd) begin
            case (funct3)
                LD_LB, LD_LBU: ok = 1'b1;
                LD_LH, LD_LHU: ok = ~off[0];
                LD_LW:         ok = (off == 2'b00);
                default:       ok = 1'b0;
            endcase
        end else if (wr) begin
            case (funct3)
                ST_SB:   ok = 1'b1;
                ST_SH:   ok = ~off[0];
                ST_SW:   ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store byte enables / lane replication and
// load extraction with sign or zero extension.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int NB_WORD = 32
) (
    input  logic [2:0]         st_funct3,
    input  logic [1:0]         st_off,
    input  logic [NB_WORD-1:0] st_data,
    output logic [NB_BE-1:0]   st_be,
    output logic [NB_WORD-1:0] st_lane_data,
    input  logic [2:0]         ld_funct3,
    input  logic [1:0]         ld_off,
    input  logic [NB_WORD-1:0] ld_word,
    output logic [NB_WORD-1:0] ld_data
);

    logic [NB_WORD-1:0] ld_shift;

    always_comb begin
        st_be        = BE_WORD;
        st_lane_data = st_data;
        case (st_funct3)
            ST_SB: begin
                st_be        = BE_BYTE << st_off;
                st_lane_data = {(NB_WORD/8){st_data[7:0]}};
            end
            ST_SH: begin
                st_be        = BE_HALF << {st_off[1], 1'b0};
                st_lane_data = {(NB_WORD/16){st_data[15:0]}};
            end
            default: begin
                st_be        = BE_WORD;
                st_lane_data = st_data;
            end
        endcase
    end

    assign ld_shift = ld_word >> {ld_off, 3'b000};

    always_comb begin
        ld_data = ld_word;
        case (ld_funct3)
            LD_LB:   ld_data = {{(NB_WORD-8){ld_shift[7]}}, ld_shift[7:0]};
            LD_LH:   ld_data = {{(NB_WORD-16){ld_shift[15]}}, ld_shift[15:0]};
            LD_LBU:  ld_data = {{(NB_WORD-8){1'b0}}, ld_shift[7:0]};
            LD_LHU:  ld_data = {{(NB_WORD-16){1'b0}}, ld_shift[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// MEM-stage load/store unit with req/ack data-memory handshake and stall.
// Optional REQ watchdog enabled by defining RISCV_LSU_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a MEM-stage access; illegal ones fault here
// REQ   | o_mem_req held with stable addr/we/be/wdata until ack
// DONE  | one cycle: load result registered, o_rdata_valid pulses
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int NB_WORD        = 32,
    parameter int NB_ADDR        = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_dmem_rd,
    input  logic               i_dmem_wr,
    input  logic [2:0]         i_funct3,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_WORD-1:0] i_wdata,
    output logic               o_stall,
    output logic [NB_WORD-1:0] o_rdata,
    output logic               o_rdata_valid,
    output logic               o_fault,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_BE-1:0]   o_mem_be,
    output logic [NB_WORD-1:0] o_mem_wdata,
    input  logic               i_mem_ack,
    input  logic [NB_WORD-1:0] i_mem_rdata
);

    lsu_state_t         state;
    logic               req_seen;
    logic               req_legal;
    logic [2:0]         ld_funct3_q;
    logic [1:0]         ld_off_q;
    logic [NB_BE-1:0]   st_be;
    logic [NB_WORD-1:0] st_lane_data;
    logic [NB_WORD-1:0] ld_data;

`ifdef RISCV_LSU_TIMEOUT_EN
    localparam int NB_TMO = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [NB_TMO-1:0] tmo_cnt;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

    assign req_seen  = i_valid & (i_dmem_rd | i_dmem_wr);
    assign req_legal = lsu_req_legal(i_dmem_rd, i_dmem_wr, i_funct3, i_addr[1:0]);

    assign o_stall = (state == REQ) | ((state == IDLE) & req_seen & req_legal);

    // Store lanes come from the live request; load extraction uses the
    // funct3/offset captured at accept, applied to the word returned with ack.
    riscv_lsu_align #(
        .NB_WORD (NB_WORD)
    ) u_align (
        .st_funct3    (i_funct3),
        .st_off       (i_addr[1:0]),
        .st_data      (i_wdata),
        .st_be        (st_be),
        .st_lane_data (st_lane_data),
        .ld_funct3    (ld_funct3_q),
        .ld_off       (ld_off_q),
        .ld_word      (i_mem_rdata),
        .ld_data      (ld_data)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_fault       <= 1'b0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_be      <= '0;
            o_mem_wdata   <= '0;
            ld_funct3_q   <= '0;
            ld_off_q      <= '0;
`ifdef RISCV_LSU_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            o_fault       <= 1'b0;
            o_rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_seen) begin
                        if (req_legal) begin
                            state       <= REQ;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_dmem_wr;
                            o_mem_addr  <= {i_addr[NB_ADDR-1:2], 2'b00};
                            o_mem_be    <= i_dmem_wr ? st_be : BE_WORD;
                            o_mem_wdata <= st_lane_data;
                            ld_funct3_q <= i_funct3;
                            ld_off_q    <= i_addr[1:0];
`ifdef RISCV_LSU_TIMEOUT_EN
                            tmo_cnt     <= '0;
`endif
                        end else begin
                            o_fault <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_ack) begin
                        state     <= DONE;
                        o_mem_req <= 1'b0;
                        if (!o_mem_we) begin
                            o_rdata       <= ld_data;
                            o_rdata_valid <= 1'b1;
                        end
                    end
`ifdef RISCV_LSU_TIMEOUT_EN
                    else if (tmo_cnt == NB_TMO'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        o_mem_req <= 1'b0;
                        o_fault   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
